// File: rtl/a2d_pkg.sv
// Shared types and command-word layout for the A2D SPI request interface.
package a2d_pkg;

    typedef enum logic [2:0] {IDLE, CMD, GAP, READ, DONE} a2d_state_e;

    localparam int unsigned BIT_CNT  = 16;
    localparam logic [1:0]  CMD_PAD  = 2'b00;
    localparam logic [10:0] CMD_TAIL = 11'h000;

    function automatic logic [BIT_CNT-1:0] cmd_word(input logic [2:0] ch);
        return {CMD_PAD, ch, CMD_TAIL};
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// Single 16-bit SPI transaction: SCLK idles high, data changes on the fall, MISO sampled
// on the rise, followed by a half-period back porch before SS_n deasserts.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrt,
    input  logic [BIT_CNT-1:0]  tx,
    output logic                done,
    output logic [BIT_CNT-1:0]  rx,
    input  logic                miso,
    output logic                ss_n,
    output logic                sclk,
    output logic                mosi
);
    localparam int unsigned HALF = SCLK_DIV / 2;
    localparam int unsigned DivW = $clog2(SCLK_DIV);
    localparam int unsigned PerW = $clog2(BIT_CNT + 1);

    logic               busy_q;
    logic [DivW-1:0]    div_q;
    logic [PerW-1:0]    per_q;
    logic               ss_n_q;
    logic               sclk_q;
    logic [BIT_CNT-1:0] tx_q;
    logic [BIT_CNT-1:0] rx_q;

    logic period_end;
    logic half_end;
    logic in_bits;

    assign period_end = (div_q == DivW'(SCLK_DIV - 1));
    assign half_end   = (div_q == DivW'(HALF - 1));
    assign in_bits    = (per_q < PerW'(BIT_CNT));
    // Period index BIT_CNT is the back porch; it ends after half a period.
    assign done       = busy_q && !in_bits && half_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= '0;
            per_q  <= '0;
            ss_n_q <= 1'b1;
            sclk_q <= 1'b1;
            tx_q   <= '0;
            rx_q   <= '0;
        end else if (!busy_q) begin
            if (wrt) begin
                busy_q <= 1'b1;
                ss_n_q <= 1'b0;
                sclk_q <= 1'b0;
                div_q  <= '0;
                per_q  <= '0;
                tx_q   <= tx;
            end
        end else if (done) begin
            busy_q <= 1'b0;
            ss_n_q <= 1'b1;
            sclk_q <= 1'b1;
            div_q  <= '0;
            per_q  <= '0;
            tx_q   <= '0;
        end else if (period_end) begin
            div_q <= '0;
            per_q <= per_q + 1'b1;
            if (per_q < PerW'(BIT_CNT - 1)) begin
                sclk_q <= 1'b0;
                tx_q   <= {tx_q[BIT_CNT-2:0], 1'b0};
            end
        end else begin
            div_q <= div_q + 1'b1;
            if (half_end && in_bits) begin
                sclk_q <= 1'b1;
                rx_q   <= {rx_q[BIT_CNT-2:0], miso};
            end
        end
    end

    assign ss_n = ss_n_q;
    assign sclk = sclk_q;
    assign mosi = tx_q[BIT_CNT-1];
    assign rx   = rx_q;

endmodule

// File: rtl/a2d_spi_intf.sv
// A2D request responder: channel-select then read transaction to the 8-channel ADC.
// Define A2D_RES_INV_EN to return the bitwise-inverted 12-bit reading.
module a2d_spi_intf
    import a2d_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 32,
    parameter int unsigned GAP_CLKS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    input  logic        MISO,
    output logic [11:0] res,
    output logic        cnv_cmplt,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI
);
    localparam int unsigned GapW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

    a2d_state_e         state_q, state_d;
    logic [2:0]         chnnl_q;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [11:0]        res_q;
    logic               cmplt_q;

    logic               wrt;
    logic               done;
    logic               latch_ch;
    logic               set_res;
    logic [BIT_CNT-1:0] tx;
    logic [BIT_CNT-1:0] rx;
    logic [11:0]        rx_res;
    logic [3:0]         rx_hi_unused;

    assign rx_hi_unused = rx[15:12];

`ifdef A2D_RES_INV_EN
    assign rx_res = ~rx[11:0];
`else
    assign rx_res = rx[11:0];
`endif

    // The accept cycle uses the live channel since chnnl_q is only loaded on that edge.
    assign tx = cmd_word((state_q == IDLE) ? chnnl : chnnl_q);

    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        wrt      = 1'b0;
        latch_ch = 1'b0;
        set_res  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    state_d  = CMD;
                    wrt      = 1'b1;
                    latch_ch = 1'b1;
                end
            end
            CMD: begin
                if (done) begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            GAP: begin
                if (gap_q == GapW'(GAP_CLKS - 1)) begin
                    state_d = READ;
                    wrt     = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            READ: begin
                if (done) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
                set_res = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chnnl_q <= '0;
            gap_q   <= '0;
            res_q   <= '0;
            cmplt_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            if (latch_ch) begin
                chnnl_q <= chnnl;
                cmplt_q <= 1'b0;
            end
            if (set_res) begin
                res_q   <= rx_res;
                cmplt_q <= 1'b1;
            end
        end
    end

    spi_mstr16 #(
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .clk   (clk),
        .rst_n (rst_n),
        .wrt   (wrt),
        .tx    (tx),
        .done  (done),
        .rx    (rx),
        .miso  (MISO),
        .ss_n  (SS_n),
        .sclk  (SCLK),
        .mosi  (MOSI)
    );

    assign res       = res_q;
    assign cnv_cmplt = cmplt_q;

endmodule
